// File: rtl/vend_pkg.sv
// Shared definitions for the change dispenser: coin codes, coin values in
// nickel units, and the dispenser state encoding.
package vend_pkg;

  localparam logic [1:0] COIN_NONE   = 2'b00;
  localparam logic [1:0] COIN_NICKEL = 2'b01;
  localparam logic [1:0] COIN_DIME   = 2'b10;

  localparam int NICKEL_VAL = 1;
  localparam int DIME_VAL   = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SELECT = 2'd1,
    ST_EJECT  = 2'd2,
    ST_DONE   = 2'd3
  } vend_state_t;

endpackage

// File: rtl/vend_inv_counter.sv
// Saturating up/down inventory counter. A simultaneous inc and dec cancel,
// increments stop at all-ones and decrements stop at zero.
module vend_inv_counter #(
  parameter int INV_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  output logic [INV_W-1:0] count
);

  localparam logic [INV_W-1:0] CNT_MAX = {INV_W{1'b1}};

  // Count register with saturation at both ends.
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (inc && !dec && count != CNT_MAX) begin
      count <= count + INV_W'(1);
    end else if (dec && !inc && count != '0) begin
      count <= count - INV_W'(1);
    end
  end

endmodule

// File: rtl/vend_change_dispenser.sv
// Change dispenser: pays a refund (in nickel units) greedily, dimes first,
// through a valid/ack coin ejector, limited by the dime/nickel inventory.
// Optional ejector watchdog: define VEND_EJECT_TIMEOUT_EN.
module vend_change_dispenser
  import vend_pkg::*;
#(
  parameter int AMT_W         = 4,
  parameter int INV_W         = 8,
  parameter int EJECT_TIMEOUT = 255
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [AMT_W-1:0] amount,
  output logic [1:0]       coin_out,
  output logic             coin_valid,
  input  logic             coin_ack,
  input  logic             load_dime,
  input  logic             load_nickel,
  output logic [INV_W-1:0] dime_count,
  output logic [INV_W-1:0] nickel_count,
  output logic             busy,
  output logic             done,
  output logic             short,
  output logic [AMT_W-1:0] shortfall,
  output logic             fault
);

  vend_state_t      state_q, state_d;
  logic [AMT_W-1:0] remaining_q, remaining_d;
  logic [1:0]       coin_sel_q, coin_sel_d;
  logic             short_q, short_d;
  logic [AMT_W-1:0] shortfall_q, shortfall_d;
  logic             dime_dec, nickel_dec;

`ifdef VEND_EJECT_TIMEOUT_EN
  localparam int TMR_W = $clog2(EJECT_TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(EJECT_TIMEOUT - 1);

  logic [TMR_W-1:0] tmr_q;
  logic             fault_q, fault_d;

  // Watchdog counts EJECT cycles; it is zero on the first cycle of each eject.
  always_ff @(posedge clock) begin
    if (reset || state_q != ST_EJECT) begin
      tmr_q <= '0;
    end else begin
      tmr_q <= tmr_q + TMR_W'(1);
    end
  end

  // Fault flag is held with short/shortfall until the next start.
  always_ff @(posedge clock) begin
    if (reset) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end

  assign fault = fault_q;
`else
  // EJECT_TIMEOUT only sizes the watchdog; it stays in the parameter list so
  // both builds present the same interface.
  if (EJECT_TIMEOUT < 0) begin : g_timeout_unused
  end

  assign fault = 1'b0;
`endif

  // State, remaining amount, selected coin and completion status registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      coin_sel_q  <= COIN_NONE;
      short_q     <= 1'b0;
      shortfall_q <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      coin_sel_q  <= coin_sel_d;
      short_q     <= short_d;
      shortfall_q <= shortfall_d;
    end
  end

  // Next-state logic: greedy coin choice in SELECT, handshake in EJECT.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    coin_sel_d  = coin_sel_q;
    short_d     = short_q;
    shortfall_d = shortfall_q;
    dime_dec    = 1'b0;
    nickel_dec  = 1'b0;
`ifdef VEND_EJECT_TIMEOUT_EN
    fault_d     = fault_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          remaining_d = amount;
          short_d     = 1'b0;
          shortfall_d = '0;
`ifdef VEND_EJECT_TIMEOUT_EN
          fault_d     = 1'b0;
`endif
          state_d     = ST_SELECT;
        end
      end
      ST_SELECT: begin
        if (remaining_q == '0) begin
          short_d     = 1'b0;
          shortfall_d = '0;
          state_d     = ST_DONE;
        end else if (remaining_q >= AMT_W'(DIME_VAL) && dime_count != '0) begin
          coin_sel_d = COIN_DIME;
          state_d    = ST_EJECT;
        end else if (nickel_count != '0) begin
          coin_sel_d = COIN_NICKEL;
          state_d    = ST_EJECT;
        end else begin
          short_d     = 1'b1;
          shortfall_d = remaining_q;
          state_d     = ST_DONE;
        end
      end
      ST_EJECT: begin
        // An ack on the watchdog's last cycle still counts the coin.
        if (coin_ack) begin
          if (coin_sel_q == COIN_DIME) begin
            dime_dec    = 1'b1;
            remaining_d = remaining_q - AMT_W'(DIME_VAL);
          end else begin
            nickel_dec  = 1'b1;
            remaining_d = remaining_q - AMT_W'(NICKEL_VAL);
          end
          coin_sel_d = COIN_NONE;
          state_d    = ST_SELECT;
        end
`ifdef VEND_EJECT_TIMEOUT_EN
        else if (tmr_q == TMR_LAST) begin
          coin_sel_d  = COIN_NONE;
          short_d     = 1'b1;
          shortfall_d = remaining_q;
          fault_d     = 1'b1;
          state_d     = ST_DONE;
        end
`endif
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  vend_inv_counter #(.INV_W(INV_W)) u_dime_inv (
    .clock (clock),
    .reset (reset),
    .inc   (load_dime),
    .dec   (dime_dec),
    .count (dime_count)
  );

  vend_inv_counter #(.INV_W(INV_W)) u_nickel_inv (
    .clock (clock),
    .reset (reset),
    .inc   (load_nickel),
    .dec   (nickel_dec),
    .count (nickel_count)
  );

  // coin_sel_q is only non-NONE while in EJECT, so it drives coin_out directly.
  assign coin_out   = coin_sel_q;
  assign coin_valid = (state_q == ST_EJECT);
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign short      = short_q;
  assign shortfall  = shortfall_q;

endmodule
